// File: rtl/mc_control_unit.sv
// Multicycle RV32 main controller: decode plus Moore sequencer.
// Drives datapath selects/enables, branch resolution and illegal-op halt.
module mc_control_unit #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7b5,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Carry,
  input  logic       Overflow,
  input  logic       mem_ready,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    AUIPC    = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRLINK = 4'd12,
    BRANCH   = 4'd13,
    ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  state_t     state_q, state_d;
  logic [2:0] alu_dec;
  logic       alu_ok, taken, br_ok;
  logic       reg_we, ir_we, pc_we, mem_we;

  always_comb begin
    alu_ok  = 1'b1;
    alu_dec = 3'b000;
    unique case (func3)
      3'b000: alu_dec = (op == OP_R && func7b5) ? 3'b001 : 3'b000;
      3'b001: alu_dec = 3'b110;
      3'b010: alu_dec = 3'b101;
      3'b011: alu_ok  = 1'b0;
      3'b100: alu_dec = 3'b100;
      3'b101: begin
        alu_dec = 3'b111;
        alu_ok  = !func7b5;
      end
      3'b110: alu_dec = 3'b011;
      3'b111: alu_dec = 3'b010;
    endcase
  end

  // Carry set means the subtraction did not borrow (A >= B unsigned).
  always_comb begin
    taken = 1'b0;
    br_ok = 1'b1;
    unique case (func3)
      3'b000: taken = Zero;
      3'b001: taken = !Zero;
      3'b100: taken = Negative ^ Overflow;
      3'b101: taken = !(Negative ^ Overflow);
      3'b110: taken = !Carry;
      3'b111: taken = Carry;
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LD, OP_ST: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_JR:        state_d = JALR;
          OP_BR:        state_d = BRANCH;
          OP_AUI:       state_d = AUIPC;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (func3 != 3'b010) state_d = ILLEGAL;
        else if (op == OP_ST) state_d = MEMWRITE;
        else state_d = MEMREAD;
      end
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR,
      EXECI:    state_d = alu_ok ? ALUWB : ILLEGAL;
      ALUWB:    state_d = FETCH;
      AUIPC:    state_d = ALUWB;
      JAL:      state_d = ALUWB;
      JALR:     state_d = JALRLINK;
      JALRLINK: state_d = FETCH;
      BRANCH:   state_d = br_ok ? FETCH : ILLEGAL;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    reg_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ImmSrc     = 3'b000;
    ALUControl = 3'b000;
    unique case (state_q)
      FETCH: begin
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
      end
      MEMADR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        ImmSrc  = (op == OP_ST) ? 3'b001 : 3'b000;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'd1;
        reg_we    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = 2'd2;
        ALUControl = alu_dec;
      end
      EXECI: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        ALUControl = alu_dec;
      end
      ALUWB:    reg_we = 1'b1;
      AUIPC: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        ImmSrc  = 3'b100;
      end
      JAL: begin
        pc_we   = 1'b1;
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
      end
      JALR: begin
        ALUSrcA   = 2'd2;
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        pc_we     = 1'b1;
      end
      JALRLINK: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        reg_we    = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 2'd2;
        ALUControl = 3'b001;
        pc_we      = taken && br_ok;
      end
      default: ;
    endcase
  end

  assign RegWrite = reg_we & ~reset;
  assign IRWrite  = ir_we  & ~reset;
  assign PCWrite  = pc_we  & ~reset;
  assign MemWrite = mem_we & ~reset;
  assign illegal  = (state_q == ILLEGAL);
  assign state    = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed plan steps then random instructions,
// each walked phase by phase through an instruction-level reference model.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7b5;
  logic       Zero, Negative, Carry, Overflow;
  logic       mem_ready;
  logic       RegWrite, IRWrite, AdrSrc, PCWrite, MemWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic       illegal;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       fetch, ill, rw, irw, adr, pcw, mw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm, alu;
  } vec_t;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .op(op), .func3(func3),
    .func7b5(func7b5), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .PCWrite(PCWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .state(state)
  );

  task automatic noise();
    mem_ready = 1'($urandom);
    Zero      = 1'($urandom);
    Negative  = 1'($urandom);
    Carry     = 1'($urandom);
    Overflow  = 1'($urandom);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic chk(input vec_t e, input string tag);
    vec_t o;
    #1;
    o.fetch = (state == 4'd0);
    o.ill   = illegal;
    o.rw    = RegWrite;
    o.irw   = IRWrite;
    o.adr   = AdrSrc;
    o.pcw   = PCWrite;
    o.mw    = MemWrite;
    o.rs    = ResultSrc;
    o.sa    = ALUSrcA;
    o.sb    = ALUSrcB;
    o.imm   = ImmSrc;
    o.alu   = ALUControl;
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    @(negedge clk);
  endtask

  function automatic void alu_ref(input logic [2:0] f3, input logic f7,
                                  input bit isr, output logic [2:0] code,
                                  output bit ok);
    ok   = 1'b1;
    code = 3'b000;
    case (f3)
      3'd0: code = (isr && f7) ? 3'b001 : 3'b000;
      3'd1: code = 3'b110;
      3'd2: code = 3'b101;
      3'd3: ok   = 1'b0;
      3'd4: code = 3'b100;
      3'd5: begin code = 3'b111; ok = !f7; end
      3'd6: code = 3'b011;
      default: code = 3'b010;
    endcase
  endfunction

  task automatic run(input logic [31:0] w, input int fw, input int mw,
                     input logic [31:0] a, input logic [31:0] b,
                     input int ill_cycles, input bit abort);
    vec_t e;
    logic [6:0] o7;
    logic [2:0] f3;
    logic [2:0] code;
    logic [31:0] d;
    bit ok, bad, st, tk, wb;
    o7 = w[6:0];
    f3 = w[14:12];
    op = o7;
    func3 = f3;
    func7b5 = w[30];
    bad = 0;
    wb = 0;
    for (int i = 0; i <= fw; i++) begin
      noise();
      mem_ready = (i == fw);
      e = '0; e.fetch = 1; e.sb = 2; e.rs = 2;
      e.irw = mem_ready; e.pcw = mem_ready;
      chk(e, "fetch");
    end
    noise();
    e = '0; e.sa = 1; e.sb = 1;
    e.imm = (o7 == 7'b1101111) ? 3'd3 : 3'd2;
    chk(e, "decode");
    case (o7)
      7'b0000011, 7'b0100011: begin
        st = (o7 == 7'b0100011);
        noise();
        e = '0; e.sa = 2; e.sb = 1; e.imm = st ? 3'd1 : 3'd0;
        chk(e, "memadr");
        if (f3 != 3'd2) bad = 1;
        else begin
          for (int i = 0; i <= mw; i++) begin
            noise();
            mem_ready = (i == mw);
            e = '0; e.adr = 1; e.mw = st;
            if (abort && i == 1) begin
              reset = 1; mem_ready = 0; e.mw = 0;
              chk(e, "reset_in_memread");
              reset = 0;
              return;
            end
            chk(e, st ? "memwrite" : "memread");
          end
          if (!st) begin
            noise();
            e = '0; e.rs = 1; e.rw = 1;
            chk(e, "memwb");
          end
        end
      end
      7'b0110011, 7'b0010011: begin
        alu_ref(f3, w[30], o7 == 7'b0110011, code, ok);
        noise();
        e = '0; e.sa = 2; e.sb = (o7 == 7'b0110011) ? 2'd0 : 2'd1;
        e.alu = code;
        chk(e, "exec");
        if (ok) wb = 1; else bad = 1;
      end
      7'b0010111: begin
        noise();
        e = '0; e.sa = 1; e.sb = 1; e.imm = 3'd4;
        chk(e, "auipc");
        wb = 1;
      end
      7'b1101111: begin
        noise();
        e = '0; e.pcw = 1; e.sa = 1; e.sb = 2;
        chk(e, "jal");
        wb = 1;
      end
      7'b1100111: begin
        noise();
        e = '0; e.sa = 2; e.sb = 1; e.rs = 2; e.pcw = 1;
        chk(e, "jalr");
        noise();
        e = '0; e.sa = 1; e.sb = 2; e.rs = 2; e.rw = 1;
        chk(e, "jalrlink");
      end
      7'b1100011: begin
        d = a - b;
        mem_ready = 1'($urandom);
        Zero      = (a == b);
        Negative  = d[31];
        Carry     = (a >= b);
        Overflow  = (a[31] != b[31]) && (d[31] != a[31]);
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: begin tk = 0; bad = 1; end
        endcase
        e = '0; e.sa = 2; e.alu = 3'b001; e.pcw = tk;
        chk(e, "branch");
      end
      default: bad = 1;
    endcase
    if (wb) begin
      noise();
      e = '0; e.rw = 1;
      chk(e, "aluwb");
    end
    if (bad) begin
      for (int i = 0; i < ill_cycles; i++) begin
        noise();
        e = '0; e.ill = 1;
        chk(e, "illegal_hold");
      end
      reset = 1;
      noise();
      e = '0; e.ill = 1;
      chk(e, "illegal_reset");
      reset = 0;
    end
  endtask

  initial begin
    vec_t e;
    logic [31:0] w, a, b;
    logic [6:0] ops [10];
    int k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0110111, 7'b1100011};
    reset = 1; op = 0; func3 = 0; func7b5 = 0;
    Zero = 0; Negative = 0; Carry = 0; Overflow = 0;
    mem_ready = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1;
      e = '0; e.fetch = 1; e.sb = 2; e.rs = 2;
      chk(e, "reset_fetch");
    end
    reset = 0;
    run(32'h00500093, 0, 0, 0, 0, 0, 0);
    run(32'h0020A023, 1, 2, 0, 0, 0, 0);
    run(32'h00208463, 0, 0, 32'd5, 32'd5, 0, 0);
    run(32'h00208463, 0, 0, 32'd5, 32'd6, 0, 0);
    run(32'h0020E463, 0, 0, 32'd1, 32'd2, 0, 0);
    run(32'h008000EF, 0, 0, 0, 0, 0, 0);
    run(32'h40105093, 0, 0, 0, 0, 12, 0);
    run(32'h000000B7, 0, 0, 0, 0, 12, 0);
    run(32'h0000A103, 0, 3, 0, 0, 0, 1);
    run(32'h00500093, 0, 0, 0, 0, 0, 0);
    run(32'h0000A103, 2, 1, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      w = $urandom;
      w[6:0] = ops[k];
      if (k <= 1 && $urandom_range(0, 4) != 0) w[14:12] = 3'd2;
      if (k == 8 && $urandom_range(0, 1) == 1) w[6:0] = 7'($urandom);
      b = $urandom;
      a = ($urandom_range(0, 3) == 0) ? b : $urandom;
      run(w, $urandom_range(0, 2), $urandom_range(0, 2), a, b, 2, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
